// File: rtl/regslv_field_bank.sv
// Parametrised register-slave field bank: ENTRY registers reachable over the native
// request bus and written in parallel by hardware, with per-entry precedence and srst mapping.
module regslv_field_bank #(
  parameter int                          ADDR_WIDTH  = 64,
  parameter int                          DATA_WIDTH  = 32,
  parameter int                          ENTRY       = 8,
  parameter logic [ADDR_WIDTH-1:0]       BASE_ADDR   = '0,
  parameter int                          SRST_NUM    = 5,
  parameter logic [SRST_NUM*ENTRY-1:0]   SRST_MASK   = '1,
  parameter logic [ENTRY-1:0]            HW_PREC     = '0,
  parameter logic [ENTRY*DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                          fsm_clk,
  input  logic                          global_sync_reset_in,
  input  logic                          req_vld,
  input  logic                          wr_en,
  input  logic                          rd_en,
  input  logic [ADDR_WIDTH-1:0]         addr,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  output logic                          ack_vld,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic                          decode_err,
  input  logic [ENTRY*DATA_WIDTH-1:0]   hw_next_value,
  input  logic [ENTRY-1:0]              hw_pulse,
  output logic [ENTRY*DATA_WIDTH-1:0]   hw_curr_value,
  output logic [ENTRY-1:0]              swmod_out,
  output logic [ENTRY-1:0]              swacc_out,
  input  logic [SRST_NUM-1:0]           srst
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int SHIFT = $clog2(BYTES);
  localparam int IDXW  = (ENTRY > 1) ? $clog2(ENTRY) : 1;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(BYTES - 1);
  localparam logic [ADDR_WIDTH-1:0] ENTRY_A    = ADDR_WIDTH'(ENTRY);

  logic [ADDR_WIDTH-1:0] off;
  logic [ADDR_WIDTH-1:0] idx_full;
  logic [IDXW-1:0]       idx;
  logic                  hit;
  logic                  sw_wr;
  logic                  sw_rd;
  logic [ENTRY-1:0]      sel;
  logic [ENTRY-1:0]      wr_sel;
  logic [ENTRY-1:0]      srst_hit;
  logic [DATA_WIDTH-1:0] rd_mux;
  logic [DATA_WIDTH-1:0] regs [ENTRY];
  logic                  ack_q;

  // Full-width index compare so addresses far above the bank never alias into it.
  always_comb begin
    off      = addr - BASE_ADDR;
    idx_full = off >> SHIFT;
    idx      = idx_full[IDXW-1:0];
    hit      = req_vld && (addr >= BASE_ADDR) && ((off & ALIGN_MASK) == '0) &&
               (idx_full < ENTRY_A) && (wr_en ^ rd_en);
    sw_wr    = hit && wr_en;
    sw_rd    = hit && rd_en;
    sel      = '0;
    rd_mux   = '0;
    for (int i = 0; i < ENTRY; i++) begin
      if (idx == IDXW'(i)) begin
        sel[i] = hit;
        if (sw_rd) rd_mux = regs[i];
      end
    end
    wr_sel = sel & {ENTRY{sw_wr}};
  end

  for (genvar i = 0; i < ENTRY; i++) begin : g_entry
    logic [SRST_NUM-1:0] srst_map;
    for (genvar k = 0; k < SRST_NUM; k++) begin : g_map
      assign srst_map[k] = SRST_MASK[k*ENTRY + i];
    end
    assign srst_hit[i] = |(srst & srst_map);
    assign hw_curr_value[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
  end

  // A sw write only loses a collision when the entry is marked hardware-precedence.
  always_ff @(posedge fsm_clk) begin
    for (int i = 0; i < ENTRY; i++) begin
      if (global_sync_reset_in || srst_hit[i])
        regs[i] <= RESET_VALUE[i*DATA_WIDTH +: DATA_WIDTH];
      else if (wr_sel[i] && !(hw_pulse[i] && HW_PREC[i]))
        regs[i] <= wr_data;
      else if (hw_pulse[i])
        regs[i] <= hw_next_value[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge fsm_clk) begin
    if (global_sync_reset_in) begin
      ack_q      <= 1'b0;
      decode_err <= 1'b0;
      rd_data    <= '0;
      swmod_out  <= '0;
      swacc_out  <= '0;
    end else begin
      ack_q      <= req_vld;
      decode_err <= req_vld && !hit;
      rd_data    <= rd_mux;
      swmod_out  <= wr_sel;
      swacc_out  <= sel;
    end
  end

  // A reset arriving while an ack is pending cancels that ack in its own cycle.
  assign ack_vld = ack_q && !global_sync_reset_in;

endmodule

// File: tb/tb_regslv_field_bank.sv
// Scoreboard bench for regslv_field_bank: 7 entries at 0x100, entry 6 hw-precedence,
// srst[2] routed to entries 0 and 1 only.
module tb_regslv_field_bank;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int NE = 7;
  localparam int NS = 5;
  localparam logic [AW-1:0]    BASE = 16'h0100;
  localparam logic [NE-1:0]    HWP  = 7'b1000000;
  localparam logic [NS*NE-1:0] MASK = {7'h7f, 7'h7f, 7'h03, 7'h7f, 7'h7f};

  function automatic logic [NE*DW-1:0] mk_rv();
    logic [NE*DW-1:0] v;
    for (int i = 0; i < NE; i++) v[i*DW +: DW] = 32'h1000 + 32'(i);
    return v;
  endfunction
  localparam logic [NE*DW-1:0] RV = mk_rv();

  logic clk = 0;
  logic gsr = 1;
  logic req_vld = 0, wr_en = 0, rd_en = 0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic ack_vld, decode_err;
  logic [DW-1:0] rd_data;
  logic [NE*DW-1:0] hw_next_value = '0;
  logic [NE-1:0] hw_pulse = '0;
  logic [NE*DW-1:0] hw_curr_value;
  logic [NE-1:0] swmod_out, swacc_out;
  logic [NS-1:0] srst = '0;

  regslv_field_bank #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ENTRY(NE), .BASE_ADDR(BASE),
    .SRST_NUM(NS), .SRST_MASK(MASK), .HW_PREC(HWP), .RESET_VALUE(RV)
  ) dut (
    .fsm_clk(clk), .global_sync_reset_in(gsr), .req_vld(req_vld), .wr_en(wr_en),
    .rd_en(rd_en), .addr(addr), .wr_data(wr_data), .ack_vld(ack_vld),
    .rd_data(rd_data), .decode_err(decode_err), .hw_next_value(hw_next_value),
    .hw_pulse(hw_pulse), .hw_curr_value(hw_curr_value), .swmod_out(swmod_out),
    .swacc_out(swacc_out), .srst(srst)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic        err;
    logic [31:0] rd;
    logic [6:0]  swm;
    logic [6:0]  swa;
  } exp_t;

  exp_t q[$];
  logic [31:0] mdl [NE];
  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;
  bit mon_en = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [NE*DW-1:0] mdl_flat();
    logic [NE*DW-1:0] v;
    for (int i = 0; i < NE; i++) v[i*DW +: DW] = mdl[i];
    return v;
  endfunction

  function automatic logic [NE*DW-1:0] rep(input logic [31:0] v);
    return {NE{v}};
  endfunction

  // Drives one cycle of stimulus, records the expected response and advances the model.
  task automatic drive(input bit v, input bit w, input bit r, input logic [AW-1:0] a,
                       input logic [31:0] d, input logic [NE-1:0] hwp,
                       input logic [NE*DW-1:0] hwv, input logic [NS-1:0] sr);
    exp_t e;
    bit h, srh;
    int ix;
    logic [AW-1:0] off;
    off = a - BASE;
    ix  = int'(off >> 2);
    h   = v && (a >= BASE) && (off[1:0] == 2'b00) && (ix < NE) && (w != r);
    e.due = cyc + 1;
    e.err = !h;
    e.rd  = (h && r) ? mdl[ix] : 32'h0;
    e.swm = (h && w) ? 7'(1 << ix) : 7'h0;
    e.swa = h ? 7'(1 << ix) : 7'h0;
    if (v && !gsr) q.push_back(e);
    for (int i = 0; i < NE; i++) begin
      srh = 0;
      for (int k = 0; k < NS; k++) if (sr[k] && MASK[k*NE + i]) srh = 1;
      if (gsr || srh) mdl[i] = RV[i*DW +: DW];
      else if (h && w && ix == i && !(hwp[i] && HWP[i])) mdl[i] = d;
      else if (hwp[i]) mdl[i] = hwv[i*DW +: DW];
    end
    req_vld = v; wr_en = w; rd_en = r; addr = a; wr_data = d;
    hw_pulse = hwp; hw_next_value = hwv; srst = sr;
    @(posedge clk); #1;
    req_vld = 0; wr_en = 0; rd_en = 0; hw_pulse = '0; srst = '0;
    chk("state", hw_curr_value, mdl_flat());
  endtask

  task automatic do_rst(input int n);
    gsr = 1;
    q.delete();
    repeat (n) @(posedge clk);
    #1 gsr = 0;
    for (int i = 0; i < NE; i++) mdl[i] = RV[i*DW +: DW];
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (q.size() > 0 && q[0].due == cyc) begin
        exp_t e;
        e = q.pop_front();
        chk("ack", ack_vld, 1'b1);
        chk("decode_err", decode_err, e.err);
        chk("rd_data", rd_data, e.rd);
        chk("swmod", swmod_out, e.swm);
        chk("swacc", swacc_out, e.swa);
      end else begin
        chk("idle_ack", ack_vld, 1'b0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NE; i++) mdl[i] = 32'hx;
    @(posedge clk); #1;
    mon_en = 1;
    do_rst(1);
    chk("rst_decode_err", decode_err, 1'b0);
    chk("rst_rd_data", rd_data, 32'h0);
    for (int i = 0; i < NE; i++)
      chk("rst_val", hw_curr_value[i*DW +: DW], 32'h1000 + 32'(i));

    for (int i = 0; i < NE; i++)
      drive(1, 0, 1, BASE + 16'(4*i), 0, '0, '0, '0);

    drive(1, 1, 0, 16'h010C, 32'h12345678, '0, '0, '0);
    chk("wr3", hw_curr_value[3*DW +: DW], 32'h12345678);

    drive(1, 1, 0, 16'h0114, 32'h12345678, 7'b0100000, rep(32'h87654321), '0);
    drive(1, 1, 0, 16'h0118, 32'h12345678, 7'b1000000, rep(32'h87654321), '0);
    chk("coll_sw_wins", hw_curr_value[5*DW +: DW], 32'h12345678);
    chk("coll_hw_wins", hw_curr_value[6*DW +: DW], 32'h87654321);

    drive(0, 0, 0, '0, 0, 7'b0000111, rep(32'h12345678), '0);
    drive(0, 0, 0, '0, 0, '0, '0, 5'b00100);
    chk("srst_e0", hw_curr_value[0*DW +: DW], 32'h1000);
    chk("srst_e1", hw_curr_value[1*DW +: DW], 32'h1001);
    chk("srst_e2", hw_curr_value[2*DW +: DW], 32'h12345678);
    drive(1, 1, 0, 16'h0100, 32'hDEADBEEF, '0, '0, 5'b00100);
    chk("srst_beats_sw", hw_curr_value[0*DW +: DW], 32'h1000);

    drive(1, 0, 1, 16'h0102, 0, '0, '0, '0);
    drive(1, 1, 0, 16'h011C, 32'hAAAA5555, '0, '0, '0);
    drive(1, 0, 1, 16'h00FC, 0, '0, '0, '0);
    drive(1, 1, 1, 16'h0104, 32'hAAAA5555, '0, '0, '0);
    drive(1, 0, 0, 16'h0104, 32'hAAAA5555, '0, '0, '0);
    drive(1, 1, 0, 16'h0101, 32'hAAAA5555, '0, '0, '0);

    drive(1, 1, 0, 16'h0108, 32'hCAFEF00D, '0, '0, '0);
    drive(1, 0, 1, 16'h0108, 0, '0, '0, '0);

    drive(1, 1, 0, 16'h0110, 32'h0BADC0DE, '0, '0, '0);
    do_rst(1);
    chk("rst_after_wr", hw_curr_value[4*DW +: DW], 32'h1004);
    gsr = 1;
    drive(1, 1, 0, 16'h0110, 32'h55AA55AA, '0, '0, '0);
    gsr = 0;
    chk("req_in_rst", hw_curr_value[4*DW +: DW], 32'h1004);

    for (int n = 0; n < 60; n++) begin
      logic [AW-1:0] a;
      logic [NS-1:0] sr;
      a  = BASE + 16'(4 * $urandom_range(0, 7)) + (($urandom_range(0, 7) == 0) ? 16'h2 : 16'h0);
      sr = ($urandom_range(0, 7) == 0) ? NS'(1 << $urandom_range(0, NS - 1)) : '0;
      drive($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom), a, $urandom,
            NE'($urandom), {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
            sr);
    end

    repeat (3) @(posedge clk);
    #1 chk("queue_drained", 32'(q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/regslv_field_bank.md
# regslv_field_bank

Parametrised register-slave field bank with ENTRY software/hardware-accessible registers behind the reg_native_if. It sits below a regmst (or a regslv forwarding stage) and generalises the fixed-entry generated regslv. ENTRY, width, per-entry precedence, and the mapping of N synchronous-reset lines to entries are all parameters. It adds address-decode error reporting and registered swmod/swacc pulses for every entry.

## Interface
- ADDR_WIDTH, 64, reg_native_if address width
- DATA_WIDTH, 32, register and bus data width; power of two, ≥8
- ENTRY, 8, number of registers (1..256)
- BASE_ADDR, 0, byte address of entry 0; entry i at BASE_ADDR + i*(DATA_WIDTH/8)
- SRST_NUM, 5, number of field-level sync reset inputs (≥1)
- SRST_MASK, all-ones, SRST_NUM*ENTRY bits; bit [k*ENTRY+i] set means srst[k] resets entry i
- HW_PREC, 0, ENTRY bits; bit i set means hardware wins a same-cycle collision on entry i, clear means software wins
- RESET_VALUE, 0, ENTRY*DATA_WIDTH bits; entry i reset value is at slice [i*DATA_WIDTH +: DATA_WIDTH]

Ports:
- fsm_clk  in  1  single clock; all logic on its rising edge
- global_sync_reset_in  in  1  synchronous, active-high reset of the whole block
- req_vld  in  1  request valid, one-cycle pulse per request
- wr_en  in  1  write qualifier, sampled with req_vld
- rd_en  in  1  read qualifier, sampled with req_vld
- addr  in  ADDR_WIDTH  byte address
- wr_data  in  DATA_WIDTH  write data
- ack_vld  out  1  request completion, one-cycle pulse
- rd_data  out  DATA_WIDTH  read data, valid while ack_vld is high
- decode_err  out  1  qualifies ack_vld; high means no entry was accessed
- hw_next_value  in  ENTRY*DATA_WIDTH  hardware write data, one slice per entry
- hw_pulse  in  ENTRY  hardware write strobe per entry
- hw_curr_value  out  ENTRY*DATA_WIDTH  current register contents
- swmod_out  out  ENTRY  pulse: software write hit the entry
- swacc_out  out  ENTRY  pulse: software read or write hit the entry
- srst  in  SRST_NUM  field-level sync resets, active high

## Operation
- Decode: off = addr − BASE_ADDR. The request hits entry off/(DATA_WIDTH/8) only if all of the following hold:
  - addr ≥ BASE_ADDR
  - off is aligned (low log2(DATA_WIDTH/8) bits zero)
  - index < ENTRY
  - exactly one of wr_en/rd_en is set
- Any other request is an error: ack with decode_err=1 and rd_data=0, and no state changes.
- Per-entry next-state priority, highest first:
  1. global_sync_reset_in
  2. any srst[k] mapped to the entry by SRST_MASK
  3. the collision winner (HW_PREC)
  4. a lone sw write or a lone hw_pulse
  5. hold
- Collision means a sw write hit on entry i and hw_pulse[i] in the same cycle. HW_PREC[i]=1 loads hw_next_value; HW_PREC[i]=0 loads wr_data. The loser is discarded.
- swmod_out[i] pulses on every sw write hit, even when hardware wins the collision or an srst overrides the write.
- swacc_out[i] pulses on every read or write hit.
- A read returns the entry value before the edge on which the request is sampled; same-cycle hw/srst updates are not visible.
- hw_curr_value is the register output directly, with no extra stage.

## Timing
- Request sampled at rising edge N (req_vld=1). Register update happens at the same edge N.
- ack_vld, rd_data, decode_err, swmod_out and swacc_out are registered and high for exactly the cycle after edge N (latency 1).
- Back-to-back requests on consecutive cycles are accepted, giving throughput 1 per cycle; no backpressure.
- hw_pulse and srst take effect at the sampling edge; no handshake.
- Reset values on global_sync_reset_in=1 at an edge:
  - all entries take RESET_VALUE
  - ack_vld=0, decode_err=0, rd_data=0, swmod_out=0, swacc_out=0
  - a request sampled during reset is dropped with no ack
- Reset asserted in the cycle after a request, while the ack is pending: the ack is suppressed. Any write already applied at edge N stays applied until the reset edge overwrites it.
- srst held for several cycles holds the entry at its reset value; sw writes in that window are lost but still produce swmod/swacc/ack.

## Test plan
- Reset/readback, DATA_WIDTH=32, ENTRY=7, RESET_VALUE[i]=0x1000+i: apply global_sync_reset_in 1 cycle, then read all 7 entries -> rd_data=0x1000+i, decode_err=0, each ack exactly one cycle after req.
- SW write 0x12345678 to entry 3 -> hw_curr_value[3] = 0x12345678 after the edge; swmod_out[3] and swacc_out[3] high one cycle; all other swmod/swacc stay 0.
- Precedence with HW_PREC=0b1000000: entry 5 and entry 6 each get a sw write of 0x12345678 with hw_pulse=1 and next_value 0x87654321 in the same cycle -> entry 5 = 0x12345678, entry 6 = 0x87654321; swmod pulses on both.
- srst mapping with SRST_MASK routing srst[2] to entries 0 and 1 only: hw-write 0x12345678 to entries 0, 1 and 2, then pulse srst[2] -> entries 0 and 1 return to reset values, entry 2 stays 0x12345678.
- Decode error, BASE_ADDR=0x100: access 0x102 (misaligned), 0x11C (index 7), 0x0FC (below base), and a request with wr_en=rd_en=1 -> each acks with decode_err=1, rd_data=0, no entry change, no swmod/swacc.
- Back-to-back with reset: write entry 2 then read entry 2 on consecutive cycles -> read returns the new value. Separately, assert global_sync_reset_in the cycle after a write -> no ack, entry = reset value.
